// File: rtl/rf_wport_arb_if.sv
// Write-port handshake bundle between the WB/MC requesters and the register
// file write-port arbiter, including the scoreboard and statistics outputs.
interface rf_wport_arb_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic [15:0] stat_cnt;

  modport slave (
    input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, mc_issue, mc_issue_rd,
    output wb_ready, mc_ready, rf_we, rf_waddr, rf_wdata, busy_mask, stat_cnt
  );

  modport master (
    output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, mc_issue, mc_issue_rd,
    input  wb_ready, mc_ready, rf_we, rf_waddr, rf_wdata, busy_mask, stat_cnt
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: WB vs multicycle unit with starvation bound
// and an outstanding-MC scoreboard. RF_ARB_STATS_EN builds the starvation-stall counter.
module rf_wport_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_wport_arb_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [31:0] busy_q;

  logic wb_use, mc_use, starve, mc_ready, wb_ready, mc_win, wb_win;

  assign wb_use   = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign mc_use   = bus.mc_valid && (bus.mc_rd != 5'd0);
  assign starve   = (wait_cnt >= MAX_WAIT_W);
  // WB readiness looks only at MC's request and the counter, never at mc_ready.
  assign mc_ready = bus.mc_valid && (bus.mc_rd == 5'd0 || !wb_use || starve);
  assign wb_ready = !(mc_use && starve);
  assign mc_win   = mc_use && mc_ready;
  assign wb_win   = wb_use && wb_ready;

  assign bus.mc_ready  = mc_ready;
  assign bus.wb_ready  = wb_ready;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy_mask = busy_q;

  logic [31:0] set_vec, clr_vec;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    set_vec = '0;
    clr_vec = '0;
    if (bus.mc_issue) set_vec[bus.mc_issue_rd] = 1'b1;
    if (mc_win)       clr_vec[bus.mc_rd]       = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      // NOTE: the scoreboard is a plain register bank, so it resets like any other flop.
      busy_q     <= '0;
    end else begin
      rf_we_q <= mc_win || wb_win;
      if (mc_win) begin
        rf_waddr_q <= bus.mc_rd;
        rf_wdata_q <= bus.mc_data;
      end else if (wb_win) begin
        rf_waddr_q <= bus.wb_rd;
        rf_wdata_q <= bus.wb_data;
      end

      if (mc_use && !mc_ready) begin
        if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end

      // Set beats clear so a freshly issued op stays outstanding.
      busy_q <= ((busy_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (mc_use && starve && bus.wb_valid && stat_q != 16'hFFFF) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign bus.stat_cnt = stat_q;
`else
  assign bus.stat_cnt = '0;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed self-checking bench for rf_wport_arb (MAX_WAIT=4); honours RF_ARB_STATS_EN.
module tb_rf_wport_arb;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  rf_wport_arb_if bus ();

  rf_wport_arb #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RF_ARB_STATS_EN
  localparam logic [15:0] EXP_STAT = 16'd3;
`else
  localparam logic [15:0] EXP_STAT = 16'd0;
`endif

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.mc_valid = 1'b0; bus.mc_rd = '0; bus.mc_data = '0;
    bus.mc_issue = 1'b0; bus.mc_issue_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hAAAA_0001;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wport: we=%b addr=%0d data=%h, want 0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    n_checks++;
    if (bus.busy_mask !== 32'd0 || bus.stat_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%h stat=%0d, want 0/0", bus.busy_mask, bus.stat_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: wb_ready=%b want 1", bus.wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL reset_first_write: we=%b addr=%0d data=%h, want 1/5/aaaa0001", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL idle_hold: we=%b addr=%0d data=%h, want 0/5/aaaa0001", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 32'h7777_0007;
    for (int i = 0; i < 4; i++) begin
      bus.wb_data = 32'h3000_0000 + 32'(i);
      #1;
      n_checks++;
      if (bus.wb_ready !== 1'b1 || bus.mc_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_wb_wins[%0d]: wb_ready=%b mc_ready=%b, want 1/0", i, bus.wb_ready, bus.mc_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h3000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL starve_wb_write[%0d]: we=%b addr=%0d data=%h, want 1/3/%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 32'h3000_0000 + 32'(i));
      end
      @(negedge clk);
    end
    bus.wb_data = 32'h3000_0010;
    #1;
    n_checks++;
    if (bus.wb_ready !== 1'b0 || bus.mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_mc_forced: wb_ready=%b mc_ready=%b, want 0/1", bus.wb_ready, bus.mc_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h7777_0007) begin
      n_fail++;
      $display("FAIL starve_mc_write: we=%b addr=%0d data=%h, want 1/7/77770007", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    @(negedge clk);
    bus.mc_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_wb_resume_ready: wb_ready=%b want 1", bus.wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h3000_0010) begin
      n_fail++;
      $display("FAIL starve_wb_resume: we=%b addr=%0d data=%h, want 1/3/30000010", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    // After the override the counter is clear, so WB wins a fresh conflict.
    @(negedge clk);
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd8;
    #1;
    n_checks++;
    if (bus.wb_ready !== 1'b1 || bus.mc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_counter_cleared: wb_ready=%b mc_ready=%b, want 1/0", bus.wb_ready, bus.mc_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_null_write();
    do_reset();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9;  bus.wb_data = 32'h0909_0909;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd0;  bus.mc_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (bus.wb_ready !== 1'b1 || bus.mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL null_readies: wb_ready=%b mc_ready=%b, want 1/1", bus.wb_ready, bus.mc_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h0909_0909) begin
      n_fail++;
      $display("FAIL null_only_wb: we=%b addr=%0d data=%h, want 1/9/09090909", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    // Null-only cycles: no write pulse and the wait counter stays at 0.
    @(negedge clk);
    bus.wb_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL null_no_pulse: we=%b want 0", bus.rf_we);
    end
    @(negedge clk);
    bus.wb_valid = 1'b1; bus.mc_rd = 5'd10;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (bus.mc_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL null_wait_zero[%0d]: mc_ready=%b want 0", i, bus.mc_ready);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd12;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy_mask !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL sb_set: busy=%h want 00001000", bus.busy_mask);
    end
    @(negedge clk);
    bus.mc_issue_rd = 5'd0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy_mask !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL sb_issue_r0: busy=%h want 00001000", bus.busy_mask);
    end
    @(negedge clk);
    bus.mc_issue = 1'b0;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd12; bus.mc_data = 32'h1212_1212;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy_mask !== 32'd0 || bus.rf_waddr !== 5'd12 || bus.rf_we !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_clear: busy=%h addr=%0d we=%b, want 0/12/1", bus.busy_mask, bus.rf_waddr, bus.rf_we);
    end
    @(negedge clk);
    bus.mc_valid = 1'b0;
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd12;
    @(negedge clk);
    bus.mc_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy_mask !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL sb_set_wins: busy=%h want 00001000", bus.busy_mask);
    end
    // Asynchronous reset mid-operation clears the scoreboard and the write strobe.
    @(negedge clk);
    idle_inputs();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd20; bus.wb_data = 32'h2020_2020;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy_mask !== 32'd0 || bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%h we=%b addr=%0d, want 0/0/0", bus.busy_mask, bus.rf_we, bus.rf_waddr);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(i); bus.wb_data = 32'hB0B0_0000 + 32'(i);
      @(posedge clk); #1;
      n_checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(i) || bus.rf_wdata !== 32'hB0B0_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: we=%b addr=%0d data=%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_stats();
    do_reset();
    for (int ep = 0; ep < 3; ep++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h4444_0000 + 32'(ep);
      bus.mc_valid = 1'b1; bus.mc_rd = 5'd6; bus.mc_data = 32'h6666_0000 + 32'(ep);
      repeat (5) @(negedge clk);
      bus.mc_valid = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++;
    if (bus.stat_cnt !== EXP_STAT) begin
      n_fail++;
      $display("FAIL stat_cnt: got %0d want %0d", bus.stat_cnt, EXP_STAT);
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_starvation();
        test_null_write();
        test_scoreboard();
        test_back_to_back();
        test_stats();
      end
      begin
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
